mips_step_sequencer: RTL

Multi-cycle control sequencer for the 8-bit MIPS datapath: register file, ALU, DMEM, PC and jump unit.
- Replaces the single-cycle control path.
- Latches the opcode Instruction[7:6] and steps each instruction through FETCH/DECODE/EXEC/MEM/WB states.
- Drives per-state datapath strobes.
- Supports single-step (board button) and free-run (timer-paced) operation, plus halt and a retired-instruction counter for the 7-seg display.

---
 rtl/mips_step_sequencer_if.sv | 33 +++
 rtl/mips_step_sequencer.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/mips_step_sequencer_if.sv
// Control bundle between the step sequencer and the MIPS datapath/board I/O.
// master = sequencer side; slave = datapath / board side.
interface mips_step_sequencer_if;
    logic       Run;
    logic       Step;
    logic       Halt;
    logic [7:0] Instruction;
    logic       IR_Load;
    logic       PC_En;
    logic       Branch;
    logic       RegDst;
    logic       ALUSrc;
    logic       ALUOp;
    logic       MemRead;
    logic       MemWrite;
    logic       MemtoReg;
    logic       RegWrite;
    logic [2:0] State;
    logic       Busy;
    logic [7:0] Instr_Count;

    modport master (
        input  Run, Step, Halt, Instruction,
        output IR_Load, PC_En, Branch, RegDst, ALUSrc, ALUOp,
               MemRead, MemWrite, MemtoReg, RegWrite, State, Busy, Instr_Count
    );

    modport slave (
        output Run, Step, Halt, Instruction,
        input  IR_Load, PC_En, Branch, RegDst, ALUSrc, ALUOp,
               MemRead, MemWrite, MemtoReg, RegWrite, State, Busy, Instr_Count
    );
endinterface

// File: rtl/mips_step_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the 8-bit MIPS datapath.
// Strobes are decoded from state and latched opcode only; one instruction per Step edge or per run-timer expiry.
module mips_step_sequencer #(
    parameter int RUN_PERIOD = 16,
    parameter int TMR_W      = 8
) (
    input  logic                  Clk,
    input  logic                  Clear,
    mips_step_sequencer_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5
    } state_e;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_LW  = 2'b01;
    localparam logic [1:0] OP_SW  = 2'b10;
    localparam logic [TMR_W-1:0] TMR_RELOAD = TMR_W'(RUN_PERIOD - 1);

    state_e             state_q, state_d;
    logic [1:0]         opc_q, opc_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic               step_prev_q;
    logic [7:0]         cnt_q, cnt_d;
    logic               start;
    logic               unused_instr_bits;

    logic ir_load, pc_en, branch, reg_dst, alu_src, alu_op;
    logic mem_read, mem_write, mem_to_reg, reg_write;

    assign unused_instr_bits = ^bus.Instruction[5:0];

    // Step only counts as a rising edge seen in IDLE; edges during Busy are dropped.
    assign start = (state_q == S_IDLE) && !bus.Halt &&
                   (bus.Run ? (timer_q == '0) : (bus.Step && !step_prev_q));

    always_comb begin
        timer_d = TMR_RELOAD;
        if ((state_q == S_IDLE) && bus.Run && !bus.Halt && (timer_q != '0))
            timer_d = timer_q - TMR_W'(1);
    end

    always_comb begin
        state_d    = S_IDLE;
        opc_d      = opc_q;
        ir_load    = 1'b0;
        pc_en      = 1'b0;
        branch     = 1'b0;
        reg_dst    = 1'b0;
        alu_src    = 1'b0;
        alu_op     = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        case (state_q)
            S_IDLE:   state_d = start ? S_FETCH : S_IDLE;
            S_FETCH: begin
                ir_load = 1'b1;
                opc_d   = bus.Instruction[7:6];
                state_d = S_DECODE;
            end
            S_DECODE: state_d = S_EXEC;
            S_EXEC: begin
                case (opc_q)
                    OP_ADD: begin
                        reg_dst = 1'b1;
                        state_d = S_WB;
                    end
                    OP_LW, OP_SW: begin
                        alu_src = 1'b1;
                        state_d = S_MEM;
                    end
                    default: begin
                        branch  = 1'b1;
                        pc_en   = 1'b1;
                        state_d = S_IDLE;
                    end
                endcase
            end
            S_MEM: begin
                alu_src = 1'b1;
                if (opc_q == OP_SW) begin
                    mem_write = 1'b1;
                    pc_en     = 1'b1;
                    state_d   = S_IDLE;
                end else begin
                    mem_read   = 1'b1;
                    mem_to_reg = 1'b1;
                    state_d    = S_WB;
                end
            end
            S_WB: begin
                reg_write = 1'b1;
                pc_en     = 1'b1;
                if (opc_q == OP_LW) begin
                    mem_read   = 1'b1;
                    mem_to_reg = 1'b1;
                end else begin
                    reg_dst = 1'b1;
                end
                state_d = S_IDLE;
            end
            default:  state_d = S_IDLE;
        endcase
        cnt_d = pc_en ? cnt_q + 8'd1 : cnt_q;
    end

    always_ff @(posedge Clk or negedge Clear) begin
        if (!Clear) begin
            state_q     <= S_IDLE;
            opc_q       <= 2'b00;
            timer_q     <= TMR_RELOAD;
            step_prev_q <= 1'b1;
            cnt_q       <= 8'd0;
        end else begin
            state_q     <= state_d;
            opc_q       <= opc_d;
            timer_q     <= timer_d;
            step_prev_q <= bus.Step;
            cnt_q       <= cnt_d;
        end
    end

    assign bus.IR_Load     = ir_load;
    assign bus.PC_En       = pc_en;
    assign bus.Branch      = branch;
    assign bus.RegDst      = reg_dst;
    assign bus.ALUSrc      = alu_src;
    assign bus.ALUOp       = alu_op;
    assign bus.MemRead     = mem_read;
    assign bus.MemWrite    = mem_write;
    assign bus.MemtoReg    = mem_to_reg;
    assign bus.RegWrite    = reg_write;
    assign bus.State       = state_q;
    assign bus.Busy        = (state_q != S_IDLE);
    assign bus.Instr_Count = cnt_q;

endmodule
